// File: rtl/memory_stage.sv
// Memory pipeline stage: word loads/stores on an internal data array with
// MEM_LAT-cycle access latency, upstream stall, and the ME/WB result register.
module memory_stage #(
    parameter int INST_SIZE = 32,
    parameter int ADDR_W    = 10,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INST_SIZE-1:0] ALU_OUT,
    input  logic [4:0]           RD,
    input  logic                 MEM_WE_ME,
    input  logic                 ME_WE,
    input  logic                 MEM_REG_ME,
    input  logic [INST_SIZE-1:0] WD_ME,
    output logic [INST_SIZE-1:0] BP_MEM,
    output logic                 STALL_MEM,
    output logic [INST_SIZE-1:0] WB_DATA,
    output logic [4:0]           WB_RD,
    output logic                 WB_WE
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [INST_SIZE-1:0]  wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q;
    logic                  wb_we_q;
    logic [INST_SIZE-1:0]  mem_q [2**ADDR_W];

    logic [ADDR_W-1:0]     idx;
    logic                  mem_op;
    logic                  rd_we;
    logic                  done;
    logic                  stall;
    logic                  advance;
    logic                  unused_addr_bits;

    // Byte offset and bits beyond the array depth are dropped: addresses wrap.
    assign idx              = ALU_OUT[ADDR_W+1:2];
    assign unused_addr_bits = ^{ALU_OUT[1:0], ALU_OUT[INST_SIZE-1:ADDR_W+2]};
    assign mem_op           = MEM_WE_ME | MEM_REG_ME;
    assign rd_we            = ME_WE & (RD != 5'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (MEM_LAT == 1) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        cnt_d   = 4'd1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign advance   = ((state_q == IDLE) && !mem_op) || done;
    // Old word is read before any same-cycle store lands (read-before-write).
    assign wb_data_d = MEM_REG_ME ? mem_q[idx] : ALU_OUT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wb_data_q <= '0;
            wb_rd_q   <= 5'd0;
            wb_we_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (advance) begin
                wb_data_q <= wb_data_d;
                wb_rd_q   <= RD;
                wb_we_q   <= rd_we;
            end else begin
                wb_we_q   <= 1'b0;
            end
        end
    end

    // Array is never reset; a store aborted by reset never reaches its completion cycle.
    always_ff @(posedge clk) begin
        if (done && MEM_WE_ME) begin
            mem_q[idx] <= WD_ME;
        end
    end

    assign BP_MEM    = ALU_OUT;
    assign STALL_MEM = stall & rst;
    assign WB_DATA   = wb_data_q;
    assign WB_RD     = wb_rd_q;
    assign WB_WE     = wb_we_q;

endmodule
